// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack engine: sizing defaults, reset SP,
// command opcodes and the FSM state encoding.
package stack_unit_pkg;

   localparam int        STACK_DEPTH    = 128;
   localparam int        STACK_AW       = 7;
   localparam logic [7:0] STACK_SP_RESET = 8'h07;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PUSH_WR = 2'd1,
      POP_RD  = 2'd2,
      POP_WB  = 2'd3
   } state_t;

endpackage

// File: rtl/stack_unit_if.sv
// Command handshake between the instruction control FSM (master)
// and the stack engine (slave).
interface stack_unit_if;

   logic       cmd_valid;
   logic       cmd_op;
   logic       cmd_ready;
   logic [7:0] push_data;
   logic       done;

   modport master (
      output cmd_valid,
      output cmd_op,
      output push_data,
      input  cmd_ready,
      input  done
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  push_data,
      output cmd_ready,
      output done
   );

endinterface

// File: rtl/stack_unit_ram.sv
// Single-port stack RAM: synchronous write and synchronous read, no reset,
// so contents survive a CPU reset.
module stack_ram #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // One address port shared by both operations; the engine never reads
   // and writes in the same cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/stack_unit.sv
// 8051-style stack engine: owns SP and the stack RAM, executes PUSH/POP
// commands and drives a one-cycle load strobe for popped bytes.
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int         DEPTH    = STACK_DEPTH,
   parameter int         AW       = STACK_AW,
   parameter logic [7:0] SP_RESET = STACK_SP_RESET
) (
   input  logic         clk,
   input  logic         rst,
   stack_unit_if.slave  bus,
   input  logic         sp_we,
   input  logic [7:0]   sp_wdata,
   input  logic         flag_clr,
   output logic         out_load,
   output logic [7:0]   out_value,
   output logic [7:0]   sp,
   output logic         ovf,
   output logic         uflow
);

   state_t     state_q;
   logic [7:0] sp_q;
   logic [7:0] pushData_q;
   logic [7:0] outValue_q;
   logic       outLoad_q;
   logic       done_q;
   logic       ovf_q;
   logic       uflow_q;

   logic          pushFits;
   logic          ramWe;
   logic          ramRe;
   logic [AW-1:0] spLow;
   logic [AW-1:0] ramAddr;
   logic [7:0]    ramRdata;
   logic          ovfSet;
   logic          uflowSet;
   logic          ovf_d;
   logic          uflow_d;

   // A push only lands when the incremented SP still fits in the RAM;
   // otherwise it is reported as overflow and the RAM is left alone.
   assign pushFits = (sp_q < 8'(DEPTH - 1));
   assign ramWe    = (state_q == PUSH_WR) && pushFits;
   assign ramRe    = (state_q == POP_RD);
   assign spLow    = sp_q[AW-1:0];
   assign ramAddr  = ramWe ? (spLow + AW'(1)) : spLow;

   // Sticky flags: a new event in the same cycle as flag_clr keeps the flag set.
   assign ovfSet   = (state_q == PUSH_WR) && !pushFits;
   assign uflowSet = (state_q == POP_WB) && (sp_q == 8'h00);
   assign ovf_d    = ovfSet   | (ovf_q   & ~flag_clr);
   assign uflow_d  = uflowSet | (uflow_q & ~flag_clr);

   stack_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ramWe),
      .re    (ramRe),
      .addr  (ramAddr),
      .wdata (pushData_q),
      .rdata (ramRdata)
   );

   // Command FSM; a direct SP write in IDLE takes priority over a command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sp_q       <= SP_RESET;
         pushData_q <= 8'h00;
         outValue_q <= 8'h00;
         outLoad_q  <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         uflow_q    <= 1'b0;
      end else begin
         outLoad_q <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= ovf_d;
         uflow_q   <= uflow_d;
         case (state_q)
            IDLE: begin
               if (sp_we) begin
                  sp_q <= sp_wdata;
               end else if (bus.cmd_valid) begin
                  if (bus.cmd_op == OP_PUSH) begin
                     pushData_q <= bus.push_data;
                     state_q    <= PUSH_WR;
                  end else begin
                     state_q <= POP_RD;
                  end
               end
            end
            PUSH_WR: begin
               if (pushFits) begin
                  sp_q <= sp_q + 8'd1;
               end
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            POP_RD: begin
               state_q <= POP_WB;
            end
            POP_WB: begin
               outValue_q <= ramRdata;
               outLoad_q  <= 1'b1;
               done_q     <= 1'b1;
               if (sp_q != 8'h00) begin
                  sp_q <= sp_q - 8'd1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == IDLE) && !sp_we;
   assign bus.done      = done_q;
   assign out_load      = outLoad_q;
   assign out_value     = outValue_q;
   assign sp            = sp_q;
   assign ovf           = ovf_q;
   assign uflow         = uflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: push/pop ordering, overflow, underflow,
// sp_we priority and reset abort, each step checked with an immediate assertion.
module tb_stack_unit;
   import stack_unit_pkg::*;

   logic       clk;
   logic       rst;
   logic       sp_we;
   logic [7:0] sp_wdata;
   logic       flag_clr;
   logic       out_load;
   logic [7:0] out_value;
   logic [7:0] sp;
   logic       ovf;
   logic       uflow;

   int passCount;
   int checkCount;

   stack_unit_if busIf ();

   stack_unit dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (busIf),
      .sp_we     (sp_we),
      .sp_wdata  (sp_wdata),
      .flag_clr  (flag_clr),
      .out_load  (out_load),
      .out_value (out_value),
      .sp        (sp),
      .ovf       (ovf),
      .uflow     (uflow)
   );

   // 10 ns clock; inputs change and outputs are sampled 1 ns after each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic op, input logic [7:0] d,
                                input logic we, input logic [7:0] wd, input logic fc);
      busIf.cmd_valid = v;
      busIf.cmd_op    = op;
      busIf.push_data = d;
      sp_we           = we;
      sp_wdata        = wd;
      flag_clr        = fc;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
   endtask

   task automatic setSp(input logic [7:0] value);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, value, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("sp_we_load", sp, value);
   endtask

   // Ends in the cycle done is high, so a following command is back-to-back.
   task automatic pushCmd(input logic [7:0] data, input logic [7:0] expSp,
                          input logic expOvf);
      applyStimulus(1'b1, OP_PUSH, data, 1'b0, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("push_ready_low", {7'd0, busIf.cmd_ready}, 8'h00);
      checkOutput("push_done_early", {7'd0, busIf.done}, 8'h00);
      tick();
      checkOutput("push_done", {7'd0, busIf.done}, 8'h01);
      checkOutput("push_ready_back", {7'd0, busIf.cmd_ready}, 8'h01);
      checkOutput("push_sp", sp, expSp);
      checkOutput("push_ovf", {7'd0, ovf}, {7'd0, expOvf});
   endtask

   task automatic popCmd(input logic [7:0] expValue, input logic [7:0] expSp,
                         input logic checkValue, input logic expUflow);
      applyStimulus(1'b1, OP_POP, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("pop_rd_ready", {7'd0, busIf.cmd_ready}, 8'h00);
      checkOutput("pop_rd_load", {7'd0, out_load}, 8'h00);
      tick();
      checkOutput("pop_wb_ready", {7'd0, busIf.cmd_ready}, 8'h00);
      checkOutput("pop_wb_load", {7'd0, out_load}, 8'h00);
      tick();
      checkOutput("pop_load", {7'd0, out_load}, 8'h01);
      checkOutput("pop_done", {7'd0, busIf.done}, 8'h01);
      checkOutput("pop_sp", sp, expSp);
      checkOutput("pop_uflow", {7'd0, uflow}, {7'd0, expUflow});
      if (checkValue) checkOutput("pop_value", out_value, expValue);
      tick();
      checkOutput("pop_load_pulse", {7'd0, out_load}, 8'h00);
      checkOutput("pop_done_pulse", {7'd0, busIf.done}, 8'h00);
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // Reset and idle
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checkOutput("rst_sp", sp, 8'h07);
      checkOutput("rst_load", {7'd0, out_load}, 8'h00);
      checkOutput("rst_value", out_value, 8'h00);
      checkOutput("rst_done", {7'd0, busIf.done}, 8'h00);
      checkOutput("rst_ovf", {7'd0, ovf}, 8'h00);
      checkOutput("rst_uflow", {7'd0, uflow}, 8'h00);
      checkOutput("rst_ready", {7'd0, busIf.cmd_ready}, 8'h01);

      // LIFO ordering: mem[8]=A5, mem[9]=3C
      pushCmd(8'hA5, 8'h08, 1'b0);
      pushCmd(8'h3C, 8'h09, 1'b0);
      popCmd(8'h3C, 8'h08, 1'b1, 1'b0);
      popCmd(8'hA5, 8'h07, 1'b1, 1'b0);

      // Overflow: fill top slot with 5A, then a push at SP=7F must not write
      setSp(8'h7E);
      pushCmd(8'h5A, 8'h7F, 1'b0);
      pushCmd(8'h11, 8'h7F, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("ovf_cleared", {7'd0, ovf}, 8'h00);
      popCmd(8'h5A, 8'h7E, 1'b1, 1'b0);

      // Underflow: pop at SP=0 still strobes, SP stays 0
      setSp(8'h00);
      popCmd(8'h00, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("uflow_cleared", {7'd0, uflow}, 8'h00);

      // sp_we beats a simultaneous command; the command is taken next cycle
      applyStimulus(1'b1, OP_PUSH, 8'h77, 1'b1, 8'h20, 1'b0);
      #1;
      checkOutput("spwe_ready_low", {7'd0, busIf.cmd_ready}, 8'h00);
      tick();
      sp_we = 1'b0;
      #1;
      checkOutput("spwe_sp", sp, 8'h20);
      checkOutput("spwe_not_accepted", {7'd0, busIf.cmd_ready}, 8'h01);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("spwe_then_accept", {7'd0, busIf.cmd_ready}, 8'h00);
      tick();
      checkOutput("spwe_push_done", {7'd0, busIf.done}, 8'h01);
      checkOutput("spwe_push_sp", sp, 8'h21);
      popCmd(8'h77, 8'h20, 1'b1, 1'b0);

      // Reset while in POP_RD aborts the pop
      applyStimulus(1'b1, OP_POP, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("abort_in_pop_rd", {7'd0, busIf.cmd_ready}, 8'h00);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_sp", sp, 8'h07);
      checkOutput("abort_idle", {7'd0, busIf.cmd_ready}, 8'h01);
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort_no_load", {7'd0, out_load}, 8'h00);
         checkOutput("abort_no_done", {7'd0, busIf.done}, 8'h00);
      end
      checkOutput("abort_sp_held", sp, 8'h07);
      setSp(8'h09);
      popCmd(8'h3C, 8'h08, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
